// File: rtl/ascon_pkg.sv
// Shared FSM encoding, widths and load-count helper
// for the Ascon SoC decryption wrapper.
package ascon_pkg;

  localparam int BYTE_W  = 8;
  localparam int TAG_W   = 128;
  localparam int NONCE_W = 128;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } dec_state_e;

  function automatic int load_bits(
    input int k,
    input int l,
    input int y
  );
    int m;
    m = (k > NONCE_W) ? k : NONCE_W;
    if (TAG_W > m) m = TAG_W;
    if (l > m) m = l;
    if (y > m) m = y;
    return m;
  endfunction

endpackage

// File: rtl/Decryption.sv
// Ascon-128 decryption core, one permutation round per cycle.
// AD and ciphertext each fit in a single padded rate block.
module Decryption
  import ascon_pkg::*;
#(
  parameter int k = 128,
  parameter int r = 64,
  parameter int a = 12,
  parameter int b = 6,
  parameter int l = 16,
  parameter int y = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [k-1:0]       key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [l-1:0]       associated_data,
  input  logic [y-1:0]       ciphertext,
  output logic [y-1:0]       plaintext,
  output logic [TAG_W-1:0]   tag,
  output logic               ready
);

  localparam int W = 64;

  typedef logic [4:0][W-1:0] ascon_st_t;

  typedef enum logic [2:0] {
    C_IDLE,
    C_INIT,
    C_AD,
    C_FIN,
    C_DONE
  } core_state_e;

  localparam logic [W-1:0] IV =
    {8'(k), 8'(r), 8'(a), 8'(b), 32'h0};
  localparam logic [3:0] LAST = 4'(a - 1);

  function automatic logic [W-1:0] ror64(
    input logic [W-1:0] x,
    input int n
  );
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic ascon_st_t ascon_round(
    input ascon_st_t s,
    input logic [3:0] n
  );
    logic [W-1:0] x0, x1, x2, x3, x4;
    logic [W-1:0] t0, t1, t2, t3, t4;
    ascon_st_t o;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, 4'hf - n, n} ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = x0 ^ (~x1 & x2);
    t1 = x1 ^ (~x2 & x3);
    t2 = x2 ^ (~x3 & x4);
    t3 = x3 ^ (~x4 & x0);
    t4 = x4 ^ (~x0 & x1);
    t1 = t1 ^ t0;
    t0 = t0 ^ t4;
    t3 = t3 ^ t2;
    t2 = ~t2;
    o[0] = t0 ^ ror64(t0, 19) ^ ror64(t0, 28);
    o[1] = t1 ^ ror64(t1, 61) ^ ror64(t1, 39);
    o[2] = t2 ^ ror64(t2, 1) ^ ror64(t2, 6);
    o[3] = t3 ^ ror64(t3, 10) ^ ror64(t3, 17);
    o[4] = t4 ^ ror64(t4, 7) ^ ror64(t4, 41);
    return o;
  endfunction

  core_state_e st_q, st_d;
  ascon_st_t   s_q, s_d, s_r;
  logic [3:0]  rnd_q, rnd_d;
  logic [y-1:0] pt_q, pt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [W-1:0] key_hi, key_lo, ad_blk;

  assign key_hi = key[k-1 -: W];
  assign key_lo = key[W-1:0];
  assign ad_blk =
    {associated_data, 8'h80, {(W-l-8){1'b0}}};

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    rnd_d = rnd_q;
    pt_d  = pt_q;
    tag_d = tag_q;
    s_r   = ascon_round(s_q, rnd_q);
    unique case (st_q)
      C_IDLE, C_DONE: begin
        if (start) begin
          s_d = {nonce[W-1:0], nonce[NONCE_W-1 -: W],
                 key_lo, key_hi, IV};
          rnd_d = '0;
          st_d  = C_INIT;
        end
      end
      C_INIT: begin
        s_d   = s_r;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST) begin
          s_d[0] = s_r[0] ^ ad_blk;
          s_d[3] = s_r[3] ^ key_hi;
          s_d[4] = s_r[4] ^ key_lo;
          rnd_d  = 4'(a - b);
          st_d   = C_AD;
        end
      end
      C_AD: begin
        s_d   = s_r;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST) begin
          // Domain separation, then absorb the ciphertext block.
          pt_d   = s_r[0][W-1 -: y] ^ ciphertext;
          s_d[0] = {ciphertext, s_r[0][W-y-1:0]
                    ^ {8'h80, {(W-y-8){1'b0}}}};
          s_d[1] = s_r[1] ^ key_hi;
          s_d[2] = s_r[2] ^ key_lo;
          s_d[4] = s_r[4] ^ 64'd1;
          rnd_d  = '0;
          st_d   = C_FIN;
        end
      end
      C_FIN: begin
        s_d   = s_r;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST) begin
          tag_d = {s_r[3] ^ key_hi, s_r[4] ^ key_lo};
          st_d  = C_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= C_IDLE;
      s_q   <= '0;
      rnd_q <= '0;
      pt_q  <= '0;
      tag_q <= '0;
    end else begin
      st_q  <= st_d;
      s_q   <= s_d;
      rnd_q <= rnd_d;
      pt_q  <= pt_d;
      tag_q <= tag_d;
    end
  end

  assign plaintext = pt_q;
  assign tag       = tag_q;
  assign ready     = (st_q == C_DONE);

endmodule

// File: rtl/soc_decryption.sv
// SoC wrapper: byte-serial load, Ascon decrypt, tag check, gated readout.
// ASCON_RELEASE_UNVERIFIED_EN releases plaintext even on tag mismatch.
module soc_decryption
  import ascon_pkg::*;
#(
  parameter int k = 128,
  parameter int r = 64,
  parameter int a = 12,
  parameter int b = 6,
  parameter int l = 16,
  parameter int y = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_inputxSS,
  input  logic [31:0] inputxSI,
  input  logic [7:0]  taginxSI,
  input  logic        reg_startxSS,
  input  logic        decryption_startxSI,
  output logic        decryption_readyxSO,
  output logic        tag_validxSO,
  input  logic        reg_outxSS,
  output logic [7:0]  plaintextxSO
);

  localparam logic [CNT_W-1:0] LOAD_N =
    CNT_W'(load_bits(k, l, y));
  localparam logic [CNT_W-1:0] K_N = CNT_W'(k);
  localparam logic [CNT_W-1:0] N_N = CNT_W'(NONCE_W);
  localparam logic [CNT_W-1:0] T_N = CNT_W'(TAG_W);
  localparam logic [CNT_W-1:0] L_N = CNT_W'(l);
  localparam logic [CNT_W-1:0] Y_N = CNT_W'(y);
  localparam logic [CNT_W-1:0] B_N = CNT_W'(BYTE_W);

  dec_state_e state_q, state_d;
  logic [CNT_W-1:0]   i_q, i_d, o_q, o_d;
  logic [k-1:0]       key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [l-1:0]       ad_q, ad_d;
  logic [y-1:0]       ct_q, ct_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               ready_q, ready_d;
  logic               tag_valid_q, tag_valid_d;
  logic [BYTE_W-1:0]  pt_byte_q, pt_byte_d;

  logic             loaded;
  logic             release_ok;
  logic             core_start;
  logic             core_ready;
  logic [y-1:0]     core_pt;
  logic [TAG_W-1:0] core_tag;

  assign loaded = (i_q >= LOAD_N);

`ifdef ASCON_RELEASE_UNVERIFIED_EN
  assign release_ok = 1'b1;
`else
  assign release_ok = tag_valid_q;
`endif

  Decryption #(
    .k(k), .r(r), .a(a), .b(b), .l(l), .y(y)
  ) u_core (
    .clk             (clk),
    .rst             (rst),
    .start           (core_start),
    .key             (key_q),
    .nonce           (nonce_q),
    .associated_data (ad_q),
    .ciphertext      (ct_q),
    .plaintext       (core_pt),
    .tag             (core_tag),
    .ready           (core_ready)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    o_d         = o_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ad_d        = ad_q;
    ct_d        = ct_q;
    tag_d       = tag_q;
    ready_d     = ready_q;
    tag_valid_d = tag_valid_q;
    pt_byte_d   = pt_byte_q;
    core_start  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // A start in the same cycle as a beat wins.
        if (loaded && reg_startxSS && decryption_startxSI) begin
          core_start = 1'b1;
          state_d    = ST_RUN;
        end else if (reg_inputxSS && !loaded) begin
          if (i_q < K_N)
            key_d = {key_q[k-BYTE_W-1:0], inputxSI[7:0]};
          if (i_q < N_N)
            nonce_d = {nonce_q[NONCE_W-BYTE_W-1:0],
                       inputxSI[15:8]};
          if (i_q < L_N)
            ad_d = {ad_q[l-BYTE_W-1:0], inputxSI[23:16]};
          if (i_q < Y_N)
            ct_d = {ct_q[y-BYTE_W-1:0], inputxSI[31:24]};
          if (i_q < T_N)
            tag_d = {tag_q[TAG_W-BYTE_W-1:0], taginxSI};
          i_d = i_q + B_N;
        end
      end
      ST_RUN: begin
        if (core_ready) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        tag_valid_d = (core_tag == tag_q);
        ready_d     = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (reg_outxSS) begin
          if (o_q < Y_N) begin
            o_d       = o_q + B_N;
            pt_byte_d = release_ok
              ? BYTE_W'(core_pt >> (Y_N - B_N - o_q))
              : '0;
          end else begin
            state_d     = ST_LOAD;
            i_d         = '0;
            o_d         = '0;
            ready_d     = 1'b0;
            tag_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      i_q         <= '0;
      o_q         <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      ad_q        <= '0;
      ct_q        <= '0;
      tag_q       <= '0;
      ready_q     <= 1'b0;
      tag_valid_q <= 1'b0;
      pt_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      o_q         <= o_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ad_q        <= ad_d;
      ct_q        <= ct_d;
      tag_q       <= tag_d;
      ready_q     <= ready_d;
      tag_valid_q <= tag_valid_d;
      pt_byte_q   <= pt_byte_d;
    end
  end

  assign decryption_readyxSO = ready_q;
  assign tag_validxSO        = tag_valid_q;
  assign plaintextxSO        = pt_byte_q;

endmodule

// File: tb/tb_soc_decryption.sv
// Directed + random bench for soc_decryption against an
// S-box-table Ascon-128 encryption model.
module tb_soc_decryption;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_inputxSS;
  logic [31:0] inputxSI;
  logic [7:0]  taginxSI;
  logic        reg_startxSS;
  logic        decryption_startxSI;
  logic        decryption_readyxSO;
  logic        tag_validxSO;
  logic        reg_outxSS;
  logic [7:0]  plaintextxSO;

  int total = 0;
  int bad   = 0;

`ifdef ASCON_RELEASE_UNVERIFIED_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  soc_decryption dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_inputxSS        (reg_inputxSS),
    .inputxSI            (inputxSI),
    .taginxSI            (taginxSI),
    .reg_startxSS        (reg_startxSS),
    .decryption_startxSI (decryption_startxSI),
    .decryption_readyxSO (decryption_readyxSO),
    .tag_validxSO        (tag_validxSO),
    .reg_outxSS          (reg_outxSS),
    .plaintextxSO        (plaintextxSO)
  );

  always #5 clk = ~clk;

  logic [4:0] sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic [63:0]  ms [5];
  logic [127:0] v_key, v_nonce, v_tag;
  logic [15:0]  v_ad, v_ct, v_pt;
  bit           v_good;

  task automatic chk(input string nm,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x,
                                       input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  task automatic perm(input int nr);
    logic [63:0] nt [5];
    logic [4:0]  v, w;
    for (int rr = 12 - nr; rr < 12; rr++) begin
      ms[2] = ms[2] ^ 64'((15 - rr) * 16 + rr);
      for (int j = 0; j < 64; j++) begin
        v = {ms[0][j], ms[1][j], ms[2][j], ms[3][j], ms[4][j]};
        w = sbox[v];
        nt[0][j] = w[4];
        nt[1][j] = w[3];
        nt[2][j] = w[2];
        nt[3][j] = w[1];
        nt[4][j] = w[0];
      end
      ms[0] = nt[0] ^ rotr(nt[0], 19) ^ rotr(nt[0], 28);
      ms[1] = nt[1] ^ rotr(nt[1], 61) ^ rotr(nt[1], 39);
      ms[2] = nt[2] ^ rotr(nt[2], 1) ^ rotr(nt[2], 6);
      ms[3] = nt[3] ^ rotr(nt[3], 10) ^ rotr(nt[3], 17);
      ms[4] = nt[4] ^ rotr(nt[4], 7) ^ rotr(nt[4], 41);
    end
  endtask

  task automatic encrypt(input logic [127:0] key,
                         input logic [127:0] nonce,
                         input logic [15:0] ad,
                         input logic [15:0] pt,
                         output logic [15:0] ct,
                         output logic [127:0] tg);
    ms[0] = 64'h80400c0600000000;
    ms[1] = key[127:64];
    ms[2] = key[63:0];
    ms[3] = nonce[127:64];
    ms[4] = nonce[63:0];
    perm(12);
    ms[3] = ms[3] ^ key[127:64];
    ms[4] = ms[4] ^ key[63:0];
    ms[0] = ms[0] ^ {ad, 8'h80, 40'h0};
    perm(6);
    ms[4] = ms[4] ^ 64'h1;
    ms[0] = ms[0] ^ {pt, 8'h80, 40'h0};
    ct = ms[0][63:48];
    ms[1] = ms[1] ^ key[127:64];
    ms[2] = ms[2] ^ key[63:0];
    perm(12);
    tg = {ms[3] ^ key[127:64], ms[4] ^ key[63:0]};
  endtask

  function automatic logic [7:0] lane(input logic [127:0] x,
                                      input int w,
                                      input int bt);
    if (bt * 8 < w) return 8'(x >> (w - 8 - 8 * bt));
    return 8'($urandom);
  endfunction

  task automatic set_nominal();
    v_key   = 128'h000102030405060708090a0b0c0d0e0f;
    v_nonce = 128'h000102030405060708090a0b0c0d0e0f;
    v_ad    = 16'h0001;
    v_pt    = 16'h0203;
  endtask

  task automatic set_random();
    v_key   = {$urandom, $urandom, $urandom, $urandom};
    v_nonce = {$urandom, $urandom, $urandom, $urandom};
    v_ad    = 16'($urandom);
    v_pt    = 16'($urandom);
  endtask

  task automatic prep(input int flip);
    logic [127:0] g;
    encrypt(v_key, v_nonce, v_ad, v_pt, v_ct, g);
    v_good = (flip < 0);
    v_tag  = v_good ? g : g ^ (128'd1 << flip);
  endtask

  task automatic load_beats(input int first, input int n);
    for (int bt = first; bt < first + n; bt++) begin
      @(negedge clk);
      reg_inputxSS = 1'b1;
      inputxSI = {lane({112'd0, v_ct}, 16, bt),
                  lane({112'd0, v_ad}, 16, bt),
                  lane(v_nonce, 128, bt),
                  lane(v_key, 128, bt)};
      taginxSI = lane(v_tag, 128, bt);
    end
    @(negedge clk);
    reg_inputxSS = 1'b0;
    inputxSI     = $urandom;
  endtask

  task automatic start_pulse(input bit with_beat);
    @(negedge clk);
    reg_startxSS        = 1'b1;
    decryption_startxSI = 1'b1;
    if (with_beat) begin
      reg_inputxSS = 1'b1;
      inputxSI     = $urandom;
      taginxSI     = 8'($urandom);
    end
    @(negedge clk);
    reg_startxSS        = 1'b0;
    decryption_startxSI = 1'b0;
    reg_inputxSS        = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (decryption_readyxSO) ok = 1'b1;
    end
  endtask

  task automatic read_byte(output logic [7:0] v);
    @(negedge clk);
    reg_outxSS = 1'b1;
    @(negedge clk);
    reg_outxSS = 1'b0;
    v = plaintextxSO;
  endtask

  task automatic finish_run(input string nm, input bit with_beat);
    bit ok;
    logic [7:0] got, e0, e1;
    e0 = (v_good || REL) ? v_pt[15:8] : 8'h00;
    e1 = (v_good || REL) ? v_pt[7:0]  : 8'h00;
    start_pulse(with_beat);
    chk({nm, "_busy"}, decryption_readyxSO, 0);
    wait_ready(ok);
    chk({nm, "_ready"}, ok, 1);
    chk({nm, "_tagv"}, tag_validxSO, v_good);
    read_byte(got);
    chk({nm, "_b0"}, got, e0);
    read_byte(got);
    chk({nm, "_b1"}, got, e1);
    read_byte(got);
    chk({nm, "_end_rdy"}, decryption_readyxSO, 0);
    chk({nm, "_end_tagv"}, tag_validxSO, 0);
    chk({nm, "_end_pt"}, got, e1);
  endtask

  task automatic run_vec(input string nm, input int flip);
    prep(flip);
    load_beats(0, 16);
    finish_run(nm, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    rst                 = 1'b0;
    reg_inputxSS        = 1'b0;
    inputxSI            = '0;
    taginxSI            = '0;
    reg_startxSS        = 1'b0;
    decryption_startxSI = 1'b0;
    reg_outxSS          = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", decryption_readyxSO, 0);
    chk("rst_tagv", tag_validxSO, 0);
    chk("rst_pt", plaintextxSO, 0);
    rst = 1'b1;

    set_nominal();
    run_vec("nom", -1);

    read_byte(got);
    chk("idle_strobe", got, 8'h03);
    chk("idle_strobe_rdy", decryption_readyxSO, 0);

    set_nominal();
    run_vec("tamper", 0);

    set_nominal();
    prep(-1);
    load_beats(0, 8);
    start_pulse(1'b0);
    repeat (50) @(negedge clk);
    chk("early_idle", decryption_readyxSO, 0);
    load_beats(8, 8);
    finish_run("early", 1'b0);

    set_nominal();
    prep(-1);
    load_beats(0, 16);
    finish_run("both", 1'b1);

    set_nominal();
    prep(-1);
    load_beats(0, 16);
    start_pulse(1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rdy", decryption_readyxSO, 0);
    chk("midrst_tagv", tag_validxSO, 0);
    chk("midrst_pt", plaintextxSO, 0);
    @(negedge clk);
    rst = 1'b1;
    set_nominal();
    run_vec("rerun", -1);

    set_random();
    v_ad = 16'h0000;
    run_vec("b2b", -1);

    for (int n = 0; n < 6; n++) begin
      set_random();
      run_vec("rnd", ($urandom_range(1) == 0)
                     ? -1 : int'($urandom_range(127)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
